rpeak_tx_scheduler: RTL and testbench
=====================================

Name: rpeak_tx_scheduler

Overview:
- Shares the single UART transmitter between two sources: command_manager response bytes and an autonomous R-peak stream drained from the dout FIFO.
- In stream mode it pops the FIFO and emits framed packets: header, sample bytes MSB first, XOR checksum.
- It paces every byte against the UART busy flag.
- Sits between command_manager / u_dout_fifo and the uart tx interface.

Parameters:
- CTR_WIDTH, 24, width of R-peak sample number; NB = ceil(CTR_WIDTH/8) data bytes per packet (pad MSBs with 0).
- HDR_BYTE, 8'hA5, packet header byte.

Ports:
- i_clk  in  1  system clock (100 MHz domain).
- i_rst_n  in  1  reset, synchronous, active-low.
- i_stream_en  in  1  enable autonomous streaming (level).
- i_cmd_tx_data  in  8  command response byte.
- i_cmd_tx_valid  in  1  1-cycle strobe, byte valid.
- o_fifo_pop  out  1  1-cycle pop to dout FIFO.
- i_fifo_empty  in  1  dout FIFO empty.
- i_fifo_rdata  in  CTR_WIDTH  FIFO read data.
- i_fifo_rdata_valid  in  1  rdata valid (1 cycle after pop).
- o_tx_data  out  8  byte to UART.
- o_tx_data_valid  out  1  1-cycle strobe to UART.
- i_tx_busy  in  1  UART transmitting.
- o_cmd_overflow  out  1  sticky: command byte dropped.
- o_pkt_cnt  out  16  packets sent, wraps 0xFFFF->0.
- o_busy  out  1  state != IDLE or cmd buffer occupied.

Behaviour:
- Reset (i_rst_n=0 at posedge), taking effect mid-operation too:
  - state=IDLE; all strobes 0; o_tx_data=0; o_cmd_overflow=0; o_pkt_cnt=0.
  - Cmd buffer cleared. Any in-flight packet is abandoned with no completion.
- Cmd buffer: 1 entry.
  - i_cmd_tx_valid with buffer empty stores the byte.
  - With buffer full, the new byte is dropped and o_cmd_overflow is set (cleared only by reset).
  - Store and drain in the same cycle: the new byte is accepted, no overflow.
- States: IDLE, FETCH, WAIT_DATA, SEND, GUARD, WAIT_TX.
- IDLE, priority order:
  1. Buffer full and i_tx_busy=0: load the cmd byte into the shifter, mark kind=CMD, go to SEND.
  2. Else i_stream_en=1, i_fifo_empty=0 and i_tx_busy=0: o_fifo_pop=1 for one cycle, go to FETCH.
- FETCH -> WAIT_DATA unconditionally.
- WAIT_DATA: on i_fifo_rdata_valid, latch the word, byte index=0, csum=0, next byte=HDR_BYTE, go to SEND.
  - Missing valid: wait indefinitely. The FIFO guarantees 1-cycle latency.
- SEND:
  - o_tx_data = current byte and o_tx_data_valid=1 for exactly one cycle, then GUARD.
  - o_tx_data holds its value until the next SEND.
- GUARD: one cycle with i_tx_busy ignored (covers the UART busy rise latency), then WAIT_TX.
- WAIT_TX: wait for i_tx_busy=0, then select the next byte:
  - Sequence: HDR -> data bytes MSB first (csum ^= byte) -> csum -> done.
  - If another byte remains: SEND.
  - On done after a stream packet: o_pkt_cnt++, go to IDLE.
  - On done after a cmd byte: buffer cleared, go to IDLE.
- Packets are atomic:
  - Command bytes wait until the current packet completes.
  - Worst-case command latency = one packet.
- Deasserting i_stream_en mid-packet completes the packet; no new pop follows.
- Minimum IDLE->SEND latency: 1 cycle for cmd, 3 cycles for stream (pop, FETCH, WAIT_DATA).
- Back-to-back packets pass through IDLE, which re-arbitrates, so a pending cmd byte always wins the next slot.
- CTR_WIDTH not a multiple of 8: the top byte is zero-padded in its MSBs.

Optional Feature:
- Macro: RPEAK_TX_SEQNUM_EN.
- When defined:
  - An 8-bit sequence byte follows the header, before the data bytes.
  - It equals the current seq counter (reset 0) and is included in the checksum.
  - The counter increments on packet completion and wraps 255->0.
  - Packet length is NB+3 bytes.
- When undefined: no sequence byte and no counter logic; packet length is NB+2.

Test Plan:
1. CTR_WIDTH=24, stream_en=1, FIFO holds 0x012345, UART busy 10 cycles per byte -> exactly one pop; tx bytes A5,01,23,45,67; o_pkt_cnt=1; FIFO empty -> IDLE, o_busy=0.
2. Command byte 0x3C strobed while the stream packet in scenario 1 is at its 2nd data byte -> packet finishes intact (…,45,67), then 0x3C is sent; o_cmd_overflow=0.
3. Two cmd strobes 0x11, 0x22 on consecutive cycles while UART busy -> 0x11 sent, 0x22 dropped, o_cmd_overflow=1 and stays set until reset.
4. stream_en dropped after header of packet 0x00ABCD, FIFO still holds 0x000001 -> bytes A5,00,AB,CD,66 sent, no further pop; o_pkt_cnt=1.
5. Reset pulsed (i_rst_n=0 for 1 cycle) during WAIT_TX of a data byte -> next cycle all outputs at reset values, no further tx strobe, o_pkt_cnt=0.
6. RPEAK_TX_SEQNUM_EN defined, two packets 0x000001, 0x000002 -> A5,00,00,00,01,01 then A5,01,00,00,02,03.

Source files
------------

// File: rtl/rpeak_tx_scheduler.sv
// Arbitrates the single UART transmitter between command response bytes and framed R-peak packets.
// Optional macro RPEAK_TX_SEQNUM_EN inserts an 8-bit sequence byte after each packet header.
module rpeak_tx_scheduler #(
  parameter int          CTR_WIDTH = 24,
  parameter logic [7:0]  HDR_BYTE  = 8'hA5
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_stream_en,
  input  logic [7:0]           i_cmd_tx_data,
  input  logic                 i_cmd_tx_valid,
  output logic                 o_fifo_pop,
  input  logic                 i_fifo_empty,
  input  logic [CTR_WIDTH-1:0] i_fifo_rdata,
  input  logic                 i_fifo_rdata_valid,
  output logic [7:0]           o_tx_data,
  output logic                 o_tx_data_valid,
  input  logic                 i_tx_busy,
  output logic                 o_cmd_overflow,
  output logic [15:0]          o_pkt_cnt,
  output logic                 o_busy
);

  localparam int NB     = (CTR_WIDTH + 7) / 8;
  localparam int WORD_W = NB * 8;
`ifdef RPEAK_TX_SEQNUM_EN
  localparam int PRE = 2;
`else
  localparam int PRE = 1;
`endif
  // Byte positions within a packet, header at position 0.
  localparam logic [7:0] LAST_DATA_IDX = 8'(PRE + NB - 1);
  localparam logic [7:0] CSUM_IDX      = 8'(PRE + NB);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT_DATA, SEND, GUARD, WAIT_TX} state_t;

  function automatic logic [7:0] csum_step(input logic [7:0] csum, input logic [7:0] b);
    return csum ^ b;
  endfunction

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [7:0]          idx_q, idx_d;
  logic [7:0]          csum_q, csum_d;
  logic [7:0]          cur_byte_q, cur_byte_d;
  logic                kind_cmd_q, kind_cmd_d;
  logic                cmd_full_q, cmd_full_d;
  logic [7:0]          cmd_byte_q, cmd_byte_d;
  logic                cmd_ovf_q, cmd_ovf_d;
  logic [15:0]         pkt_cnt_q, pkt_cnt_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;
  logic                fifo_pop_q, fifo_pop_d;
  logic                busy_q, busy_d;
  logic                cmd_drain;
  logic [7:0]          next_byte;
`ifdef RPEAK_TX_SEQNUM_EN
  logic [7:0]          seq_q, seq_d;
`endif

  // Next-state, byte sequencing and command buffer logic.
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    idx_d      = idx_q;
    csum_d     = csum_q;
    cur_byte_d = cur_byte_q;
    kind_cmd_d = kind_cmd_q;
    cmd_full_d = cmd_full_q;
    cmd_byte_d = cmd_byte_q;
    cmd_ovf_d  = cmd_ovf_q;
    pkt_cnt_d  = pkt_cnt_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = 1'b0;
    fifo_pop_d = 1'b0;
    cmd_drain  = 1'b0;
    next_byte  = word_q[WORD_W-1 -: 8];
`ifdef RPEAK_TX_SEQNUM_EN
    seq_d      = seq_q;
`endif

    case (state_q)
      IDLE: begin
        if (cmd_full_q && !i_tx_busy) begin
          cur_byte_d = cmd_byte_q;
          kind_cmd_d = 1'b1;
          state_d    = SEND;
        end else if (i_stream_en && !i_fifo_empty && !i_tx_busy) begin
          fifo_pop_d = 1'b1;
          state_d    = FETCH;
        end else begin
          state_d    = IDLE;
        end
      end
      FETCH: state_d = WAIT_DATA;
      WAIT_DATA: begin
        if (i_fifo_rdata_valid) begin
          word_d     = WORD_W'(i_fifo_rdata);
          idx_d      = 8'd0;
          csum_d     = 8'd0;
          cur_byte_d = HDR_BYTE;
          kind_cmd_d = 1'b0;
          state_d    = SEND;
        end else begin
          state_d    = WAIT_DATA;
        end
      end
      SEND: begin
        tx_data_d  = cur_byte_q;
        tx_valid_d = 1'b1;
        state_d    = GUARD;
      end
      GUARD: state_d = WAIT_TX;
      WAIT_TX: begin
        if (i_tx_busy) begin
          state_d = WAIT_TX;
        end else if (kind_cmd_q) begin
          cmd_drain = 1'b1;
          state_d   = IDLE;
        end else if (idx_q < LAST_DATA_IDX) begin
`ifdef RPEAK_TX_SEQNUM_EN
          if (idx_q == 8'd0) begin
            next_byte = seq_q;
          end else begin
            next_byte = word_q[WORD_W-1 -: 8];
            word_d    = word_q << 8;
          end
`else
          next_byte = word_q[WORD_W-1 -: 8];
          word_d    = word_q << 8;
`endif
          cur_byte_d = next_byte;
          csum_d     = csum_step(csum_q, next_byte);
          idx_d      = idx_q + 8'd1;
          state_d    = SEND;
        end else if (idx_q == LAST_DATA_IDX) begin
          cur_byte_d = csum_q;
          idx_d      = CSUM_IDX;
          state_d    = SEND;
        end else begin
          pkt_cnt_d = pkt_cnt_q + 16'd1;
`ifdef RPEAK_TX_SEQNUM_EN
          seq_d     = seq_q + 8'd1;
`endif
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A byte arriving in the drain cycle takes the freed slot.
    if (i_cmd_tx_valid) begin
      if (!cmd_full_q || cmd_drain) begin
        cmd_byte_d = i_cmd_tx_data;
        cmd_full_d = 1'b1;
      end else begin
        cmd_ovf_d  = 1'b1;
      end
    end else if (cmd_drain) begin
      cmd_full_d = 1'b0;
    end else begin
      cmd_full_d = cmd_full_q;
    end

    busy_d = (state_d != IDLE) || cmd_full_d;
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      word_q     <= '0;
      idx_q      <= 8'd0;
      csum_q     <= 8'd0;
      cur_byte_q <= 8'd0;
      kind_cmd_q <= 1'b0;
      cmd_full_q <= 1'b0;
      cmd_byte_q <= 8'd0;
      cmd_ovf_q  <= 1'b0;
      pkt_cnt_q  <= 16'd0;
      tx_data_q  <= 8'd0;
      tx_valid_q <= 1'b0;
      fifo_pop_q <= 1'b0;
      busy_q     <= 1'b0;
`ifdef RPEAK_TX_SEQNUM_EN
      seq_q      <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      idx_q      <= idx_d;
      csum_q     <= csum_d;
      cur_byte_q <= cur_byte_d;
      kind_cmd_q <= kind_cmd_d;
      cmd_full_q <= cmd_full_d;
      cmd_byte_q <= cmd_byte_d;
      cmd_ovf_q  <= cmd_ovf_d;
      pkt_cnt_q  <= pkt_cnt_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      fifo_pop_q <= fifo_pop_d;
      busy_q     <= busy_d;
`ifdef RPEAK_TX_SEQNUM_EN
      seq_q      <= seq_d;
`endif
    end
  end

  assign o_fifo_pop      = fifo_pop_q;
  assign o_tx_data       = tx_data_q;
  assign o_tx_data_valid = tx_valid_q;
  assign o_cmd_overflow  = cmd_ovf_q;
  assign o_pkt_cnt       = pkt_cnt_q;
  assign o_busy          = busy_q;

endmodule

// File: tb/tb_rpeak_tx_scheduler.sv
// Scoreboard bench for rpeak_tx_scheduler: FIFO and UART models, packet/command reference model.
module tb_rpeak_tx_scheduler;
  localparam int CW = 24;
  localparam int NB = (CW + 7) / 8;
`ifdef RPEAK_TX_SEQNUM_EN
  localparam int PKT_LEN = NB + 3;
`else
  localparam int PKT_LEN = NB + 2;
`endif

  logic          i_clk;
  logic          i_rst_n;
  logic          i_stream_en;
  logic [7:0]    i_cmd_tx_data;
  logic          i_cmd_tx_valid;
  logic          o_fifo_pop;
  logic          i_fifo_empty;
  logic [CW-1:0] i_fifo_rdata;
  logic          i_fifo_rdata_valid;
  logic [7:0]    o_tx_data;
  logic          o_tx_data_valid;
  logic          i_tx_busy;
  logic          o_cmd_overflow;
  logic [15:0]   o_pkt_cnt;
  logic          o_busy;

  rpeak_tx_scheduler #(.CTR_WIDTH(CW), .HDR_BYTE(8'hA5)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_stream_en(i_stream_en),
    .i_cmd_tx_data(i_cmd_tx_data), .i_cmd_tx_valid(i_cmd_tx_valid),
    .o_fifo_pop(o_fifo_pop), .i_fifo_empty(i_fifo_empty),
    .i_fifo_rdata(i_fifo_rdata), .i_fifo_rdata_valid(i_fifo_rdata_valid),
    .o_tx_data(o_tx_data), .o_tx_data_valid(o_tx_data_valid), .i_tx_busy(i_tx_busy),
    .o_cmd_overflow(o_cmd_overflow), .o_pkt_cnt(o_pkt_cnt), .o_busy(o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_err = 0;

  // Stimulus-side state
  logic [CW-1:0] fifo_mem [256];
  int            fifo_wr = 0;
  logic [7:0]    cmd_hist [256];
  int            cmd_acc = 0;
  bit            ovf_exp = 1'b0;
  int            uart_len = 10;

  // Monitor-side state
  int            fifo_rd = 0;
  int            cmd_sent = 0;
  int            cmd_done = 0;
  logic [7:0]    pkt_q [$];
  int            pkt_done = 0;
  int            pops = 0;
  int            pop_seq = 0;
  bit            pop_pend = 1'b0;
  logic [CW-1:0] word_pend;
  int            pkt_pos = 0;
  int            uart_cnt = 0;
  int            tx_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference packet: header, [seq], data bytes MSB first, XOR of everything after the header.
  task automatic push_pkt(input logic [CW-1:0] w, input int seq);
    logic [7:0] cs;
    logic [7:0] b;
    logic [31:0] wv;
    wv = 32'(w);
    cs = 8'h00;
    pkt_q.push_back(8'hA5);
`ifdef RPEAK_TX_SEQNUM_EN
    b = 8'(seq % 256);
    pkt_q.push_back(b);
    cs = cs ^ b;
`endif
    for (int k = NB - 1; k >= 0; k--) begin
      b = 8'((wv >> (8 * k)) & 32'hFF);
      pkt_q.push_back(b);
      cs = cs ^ b;
    end
    pkt_q.push_back(cs);
  endtask

  // Monitor plus FIFO and UART responders, all evaluated on the falling edge.
  initial begin
    i_fifo_rdata       = '0;
    i_fifo_rdata_valid = 1'b0;
    i_fifo_empty       = 1'b1;
    i_tx_busy          = 1'b0;
    forever begin
      @(negedge i_clk);
      if (uart_cnt > 0) uart_cnt--;
      if (!i_rst_n) begin
        pkt_q.delete();
        cmd_sent = 0;
        cmd_done = 0;
        pkt_done = 0;
        pop_seq  = 0;
        pop_pend = 1'b0;
        pkt_pos  = 0;
        i_fifo_rdata_valid = 1'b0;
      end else begin
        i_fifo_rdata_valid = 1'b0;
        if (pop_pend) begin
          i_fifo_rdata_valid = 1'b1;
          i_fifo_rdata       = word_pend;
          pop_pend           = 1'b0;
        end
        if (o_fifo_pop) begin
          pops++;
          if (fifo_rd == fifo_wr) begin
            check("pop_on_empty", 32'd1, 32'd0);
          end else begin
            word_pend = fifo_mem[fifo_rd % 256];
            fifo_rd++;
            push_pkt(word_pend, pop_seq);
            pop_seq++;
            pop_pend = 1'b1;
          end
        end
        if (o_tx_data_valid) begin
          tx_total++;
          check("tx_idle_at_strobe", 32'(i_tx_busy), 32'd0);
          uart_cnt = uart_len;
          if (pkt_q.size() > 0) begin
            check("pkt_byte", 32'(o_tx_data), 32'(pkt_q.pop_front()));
            pkt_pos++;
            if (pkt_pos == PKT_LEN) begin
              pkt_pos = 0;
              pkt_done++;
            end
          end else if (cmd_sent < cmd_acc) begin
            check("cmd_byte", 32'(o_tx_data), 32'(cmd_hist[cmd_sent % 256]));
            cmd_sent++;
          end else begin
            check("unexpected_tx", 32'(o_tx_data), 32'hFFFF_FFFF);
          end
        end
        if (cmd_done < cmd_sent && uart_cnt == 0) cmd_done++;
      end
      i_tx_busy    = (uart_cnt > 0);
      i_fifo_empty = (fifo_rd == fifo_wr);
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic push_word(input logic [CW-1:0] w);
    fifo_mem[fifo_wr % 256] = w;
    fifo_wr++;
  endtask

  // Strobe a command byte; only called when the buffer is clearly empty or clearly held.
  task automatic send_cmd(input logic [7:0] b);
    i_cmd_tx_data  = b;
    i_cmd_tx_valid = 1'b1;
    if (cmd_acc == cmd_done) begin
      cmd_hist[cmd_acc % 256] = b;
      cmd_acc++;
    end else begin
      ovf_exp = 1'b1;
    end
    tick();
    i_cmd_tx_valid = 1'b0;
  endtask

  function automatic bit cmd_inflight();
    return (cmd_sent == cmd_acc) && (cmd_done < cmd_acc);
  endfunction

  task automatic wait_quiet(input string name);
    int quiet;
    int n;
    quiet = 0;
    n = 0;
    while (quiet < 4 && n < 4000) begin
      tick();
      n++;
      if (!o_busy && !i_tx_busy && pkt_q.size() == 0 && cmd_done == cmd_acc &&
          !(i_stream_en && fifo_rd != fifo_wr)) quiet++;
      else quiet = 0;
    end
    if (quiet < 4) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_pos(input string name, input int p);
    int n;
    n = 0;
    while (pkt_pos < p && n < 2000) begin
      tick();
      n++;
    end
    if (pkt_pos < p) check({name, "_timeout"}, 32'(pkt_pos), 32'(p));
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_tx_data"},  32'(o_tx_data), 32'd0);
    check({name, "_tx_valid"}, 32'(o_tx_data_valid), 32'd0);
    check({name, "_pop"},      32'(o_fifo_pop), 32'd0);
    check({name, "_ovf"},      32'(o_cmd_overflow), 32'd0);
    check({name, "_pkt_cnt"},  32'(o_pkt_cnt), 32'd0);
    check({name, "_busy"},     32'(o_busy), 32'd0);
  endtask

  initial begin
    int pops0;
    int tx0;
    i_rst_n = 1'b0;
    i_stream_en = 1'b0;
    i_cmd_tx_data = 8'h00;
    i_cmd_tx_valid = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    i_rst_n = 1'b1;
    tick();

    // Single packet
    push_word(24'h012345);
    i_stream_en = 1'b1;
    wait_quiet("t1");
    check("t1_pops", 32'(pops), 32'd1);
    check("t1_pkt_cnt", 32'(o_pkt_cnt), 32'd1);
    check("t1_busy", 32'(o_busy), 32'd0);
`ifndef RPEAK_TX_SEQNUM_EN
    check("t1_csum", 32'(o_tx_data), 32'h67);
`endif

    // Command arriving mid-packet waits for the packet
    push_word(24'h012345);
    wait_pos("t2", 2);
    send_cmd(8'h3C);
    wait_quiet("t2");
    check("t2_last_cmd", 32'(o_tx_data), 32'h3C);
    check("t2_ovf", 32'(o_cmd_overflow), 32'd0);
    check("t2_pkt_cnt", 32'(o_pkt_cnt), 32'd2);

    // Second command while the buffer is held is dropped
    push_word(24'h5A5A5A);
    wait_pos("t3", 1);
    send_cmd(8'h11);
    send_cmd(8'h22);
    wait_quiet("t3");
    check("t3_last_cmd", 32'(o_tx_data), 32'h11);
    check("t3_ovf", 32'(o_cmd_overflow), 32'd1);

    // Stream disabled mid-packet: packet completes, no new pop
    pops0 = pops;
    push_word(24'h00ABCD);
    push_word(24'h000001);
    wait_pos("t4", 1);
    i_stream_en = 1'b0;
    wait_quiet("t4");
    repeat (20) tick();
    check("t4_pops", 32'(pops - pops0), 32'd1);
    check("t4_fifo_level", 32'(fifo_wr - fifo_rd), 32'd1);
    check("t4_pkt_cnt", 32'(o_pkt_cnt), 32'd4);
    check("t4_ovf_sticky", 32'(o_cmd_overflow), 32'd1);
`ifndef RPEAK_TX_SEQNUM_EN
    check("t4_csum", 32'(o_tx_data), 32'h66);
`endif

    // Reset during WAIT_TX of a data byte
    i_stream_en = 1'b1;
    wait_pos("t5", 2);
    i_stream_en = 1'b0;
    i_rst_n = 1'b0;
    cmd_acc = 0;
    ovf_exp = 1'b0;
    tick();
    i_rst_n = 1'b1;
    check_reset_outputs("t5");
    tx0 = tx_total;
    repeat (30) tick();
    check("t5_no_tx", 32'(tx_total - tx0), 32'd0);
    check("t5_pkt_cnt", 32'(o_pkt_cnt), 32'd0);
    wait_quiet("t5");

    // Two packets back to back (sequence byte when enabled)
    push_word(24'h000001);
    push_word(24'h000002);
    i_stream_en = 1'b1;
    wait_quiet("t6");
    check("t6_pkt_cnt", 32'(o_pkt_cnt), 32'd2);
`ifndef RPEAK_TX_SEQNUM_EN
    check("t6_csum", 32'(o_tx_data), 32'h02);
`else
    check("t6_csum", 32'(o_tx_data), 32'h03);
`endif

    // Randomized mix of pushes, enable toggles and command strobes
    for (int it = 0; it < 600; it++) begin
      int r;
      r = $urandom_range(0, 9);
      uart_len = $urandom_range(1, 12);
      if (r <= 2 && (fifo_wr - fifo_rd) < 6) begin
        push_word(CW'($urandom));
        tick();
      end else if (r == 3) begin
        i_stream_en = ~i_stream_en;
        tick();
      end else if (r <= 5 && !cmd_inflight()) begin
        send_cmd(8'($urandom));
      end else begin
        tick();
      end
    end
    i_stream_en = 1'b1;
    wait_quiet("rand");
    check("rand_pkt_cnt", 32'(o_pkt_cnt), 32'(pkt_done));
    check("rand_ovf", 32'(o_cmd_overflow), 32'(ovf_exp));
    check("rand_cmds_sent", 32'(cmd_sent), 32'(cmd_acc));
    check("rand_busy", 32'(o_busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
